gpca_seq: RTL

// - Sequential, parametrised successor of the combinational cellular arithmetic array.
// - Iterative unit, one result bit per cycle: multiply, square, divide, square root.
// - Sits between an operand source and a result sink, with valid/ready handshakes on both sides.

---
 rtl/gpca_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gpca_seq.sv
// Iterative arithmetic unit: shift-add multiply/square, restoring divide, non-restoring sqrt.
// Optional GPCA_DZ_ERR_EN adds a dz_err port and a one-cycle divide-by-zero path.
module gpca_seq #(
  parameter  int N     = 8,
  localparam int RES_W = 2 * N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] result,
  output logic [N-1:0]     rem
`ifdef GPCA_DZ_ERR_EN
  ,
  output logic             dz_err
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_SQR  = 2'b01,
    OP_DIV  = 2'b10,
    OP_SQRT = 2'b11
  } op_t;

  localparam int CW   = $clog2(N + 1);
  localparam int HALF = N / 2;
  localparam int RW   = N + 1;

  state_t          state, state_nxt;
  op_t             op_q, mode_op;
  logic [N-1:0]    a_q, b_q, hi_q, lo_q;
  logic [RW-1:0]   sr_q;
  logic [HALF-1:0] sq_q;
  logic [CW-1:0]   cnt_q, iter;
  logic            dz_q, dz_in, finish;

  logic [N:0]      mul_sum;
  logic [N:0]      div_pr;
  logic [N-1:0]    div_diff;
  logic            div_ge;
  logic [RW-1:0]   sr_sh, sr_nxt;
  logic [HALF-1:0] sq_nxt;
  logic [N-1:0]    sqrt_rem;

  assign mode_op   = op_t'(mode);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign iter      = (op_q == OP_SQRT) ? CW'(HALF) : CW'(N);
  assign finish    = (state == RUN) && ((cnt_q == iter) || dz_q);

`ifdef GPCA_DZ_ERR_EN
  assign dz_in = (mode_op == OP_DIV) && (b == '0);
`else
  assign dz_in = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One recurrence step for each algorithm; only the one matching op_q is committed.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_pr   = {hi_q, lo_q[N-1]};
    div_ge   = (div_pr >= {1'b0, b_q});
    div_diff = div_pr[N-1:0] - b_q;
    sr_sh    = {sr_q[RW-3:0], lo_q[N-1:N-2]};
    sr_nxt   = sr_q[RW-1] ? sr_sh + RW'({sq_q, 2'b11}) : sr_sh - RW'({sq_q, 2'b01});
    sq_nxt   = {sq_q[HALF-2:0], ~sr_nxt[RW-1]};
    // A negative final partial remainder needs one restoring correction.
    sqrt_rem = sr_q[N-1:0] + (sr_q[RW-1] ? N'({sq_q, 1'b1}) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      sr_q   <= '0;
      sq_q   <= '0;
      cnt_q  <= '0;
      dz_q   <= 1'b0;
      result <= '0;
      rem    <= '0;
`ifdef GPCA_DZ_ERR_EN
      dz_err <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          op_q  <= mode_op;
          a_q   <= a;
          b_q   <= b;
          hi_q  <= '0;
          lo_q  <= (mode_op == OP_MUL) ? b : a;
          sr_q  <= '0;
          sq_q  <= '0;
          cnt_q <= '0;
          dz_q  <= dz_in;
        end
        RUN: if (finish) begin
          if (dz_q) begin
            result <= '0;
            rem    <= a_q;
`ifdef GPCA_DZ_ERR_EN
            dz_err <= 1'b1;
`endif
          end else begin
            unique case (op_q)
              OP_MUL, OP_SQR: begin result <= {hi_q, lo_q};      rem <= '0;       end
              OP_DIV:         begin result <= RES_W'(lo_q);      rem <= hi_q;     end
              OP_SQRT:        begin result <= RES_W'(sq_q);      rem <= sqrt_rem; end
            endcase
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
          unique case (op_q)
            OP_MUL, OP_SQR: begin
              hi_q <= mul_sum[N:1];
              lo_q <= {mul_sum[0], lo_q[N-1:1]};
            end
            OP_DIV: begin
              hi_q <= div_ge ? div_diff : div_pr[N-1:0];
              lo_q <= {lo_q[N-2:0], div_ge};
            end
            OP_SQRT: begin
              sr_q <= sr_nxt;
              sq_q <= sq_nxt;
              lo_q <= {lo_q[N-3:0], 2'b00};
            end
          endcase
        end
        DONE: begin
`ifdef GPCA_DZ_ERR_EN
          if (out_ready) dz_err <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
